// File: rtl/ifu_fetch.sv
// Instruction fetch: 1-cycle ITCM requests, 2-entry {pc,inst} buffer to decode, credit-limited to 2 outstanding.
// Redirect-to-decode latency 2 cycles; IFU_MISALIGN_CHK_EN adds misaligned-redirect trap and ERR hold.
module ifu_fetch #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter logic [AW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] pc_from_ifu,
    output logic          ifureq_to_itcm,
    input  logic [DW-1:0] inst_to_ifu,
    input  logic          itcm_ready_to_ifu,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid_to_idu,
    output logic [DW-1:0] inst_to_idu,
    output logic [AW-1:0] pc_to_idu,
    input  logic          idu_ready,
    output logic          misalign_to_exu,
    output logic [AW-1:0] misalign_addr_to_exu
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ERR} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_fetch_pc;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_pc;
    logic [AW-1:0] r_fifo_pc   [2];
    logic [DW-1:0] r_fifo_inst [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic [AW-1:0] w_redir_pc;
    logic          w_misalign;
    logic          w_redir_ok;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [2:0]    w_used;

`ifdef IFU_MISALIGN_CHK_EN
    assign w_redir_pc = redirect_pc;
    assign w_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    assign w_redir_pc = redirect_pc & ~{{(AW-2){1'b0}}, 2'b11};
    assign w_misalign = 1'b0;
`endif
    assign w_redir_ok = redirect_valid & ~w_misalign;

    assign pc_from_ifu       = redirect_valid ? w_redir_pc : r_fetch_pc;
    assign inst_valid_to_idu = (r_count != 2'd0) & ~redirect_valid;
    assign inst_to_idu       = r_fifo_inst[r_rd_ptr];
    assign pc_to_idu         = r_fifo_pc[r_rd_ptr];
    assign w_pop             = inst_valid_to_idu & idu_ready;

    // Occupied slots next cycle if nothing new is issued; keeps buffered + in-flight <= 2.
    assign w_used  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = w_redir_ok | ((r_state == S_FETCH) & ~redirect_valid & (w_used < 3'd2));
    assign ifureq_to_itcm = w_issue;

    // r_inflight gates stale responses from requests made before a reset.
    assign w_push = itcm_ready_to_ifu & r_inflight & ~redirect_valid & (r_state != S_ERR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_FETCH;
            S_ERR:   w_state_nxt = w_redir_ok ? S_FETCH : S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_misalign) begin
            w_state_nxt = S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= pc_from_ifu + AW'(4);
                r_inflight_pc <= pc_from_ifu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_pc[0]   <= '0;
            r_fifo_pc[1]   <= '0;
            r_fifo_inst[0] <= '0;
            r_fifo_inst[1] <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else if (redirect_valid) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
                r_fifo_inst[r_wr_ptr] <= inst_to_ifu;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    logic          r_misalign;
    logic [AW-1:0] r_misalign_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_misalign;
            if (w_misalign) begin
                r_misalign_addr <= redirect_pc;
            end
        end
    end

    assign misalign_to_exu      = r_misalign;
    assign misalign_addr_to_exu = r_misalign_addr;
`else
    assign misalign_to_exu      = 1'b0;
    assign misalign_addr_to_exu = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a 1-cycle ITCM model returning inst = pc ^ 0xC0DE5A5A.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_from_ifu;
    logic        ifureq_to_itcm;
    logic [31:0] inst_to_ifu = 32'h0;
    logic        itcm_ready_to_ifu = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid_to_idu;
    logic [31:0] inst_to_idu;
    logic [31:0] pc_to_idu;
    logic        idu_ready;
    logic        misalign_to_exu;
    logic [31:0] misalign_addr_to_exu;

    int vecs = 0;
    int miss = 0;

    ifu_fetch #(.DW(32), .AW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pc_from_ifu          (pc_from_ifu),
        .ifureq_to_itcm       (ifureq_to_itcm),
        .inst_to_ifu          (inst_to_ifu),
        .itcm_ready_to_ifu    (itcm_ready_to_ifu),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .inst_valid_to_idu    (inst_valid_to_idu),
        .inst_to_idu          (inst_to_idu),
        .pc_to_idu            (pc_to_idu),
        .idu_ready            (idu_ready),
        .misalign_to_exu      (misalign_to_exu),
        .misalign_addr_to_exu (misalign_addr_to_exu)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return pc ^ 32'hC0DE_5A5A;
    endfunction

    always @(posedge clk) begin
        itcm_ready_to_ifu <= ifureq_to_itcm;
        inst_to_ifu       <= mk(pc_from_ifu);
    end

    // Every accepted instruction must carry the data fetched from its own pc; no push into a full buffer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_valid_to_idu && idu_ready) begin
                vecs++; if (inst_to_idu !== mk(pc_to_idu)) begin miss++; $display("FAIL pair_data pc=%h got %h exp %h", pc_to_idu, inst_to_idu, mk(pc_to_idu)); end
            end
            if (dut.w_push && dut.r_count == 2'd2) begin
                vecs++; miss++; $display("FAIL push_full got push with count 2 exp no push");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++; if (pc_from_ifu !== 32'h0) begin miss++; $display("FAIL rst_pc got %h exp %h", pc_from_ifu, 32'h0); end
        vecs++; if (ifureq_to_itcm !== 1'b0) begin miss++; $display("FAIL rst_req got %b exp 0", ifureq_to_itcm); end
        vecs++; if (inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL rst_vld got %b exp 0", inst_valid_to_idu); end
        vecs++; if (inst_to_idu !== 32'h0 || pc_to_idu !== 32'h0) begin miss++; $display("FAIL rst_idu got %h/%h exp 0/0", inst_to_idu, pc_to_idu); end
        vecs++; if (misalign_to_exu !== 1'b0 || misalign_addr_to_exu !== 32'h0) begin miss++; $display("FAIL rst_mis got %b/%h exp 0/0", misalign_to_exu, misalign_addr_to_exu); end
        nxt(); nxt();
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        @(negedge clk);
        vecs++; if (ifureq_to_itcm !== 1'b0 || inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL idle_cycle got req=%b vld=%b exp 0/0", ifureq_to_itcm, inst_valid_to_idu); end
        nxt(); @(negedge clk);
        vecs++; if (ifureq_to_itcm !== 1'b1 || pc_from_ifu !== 32'h0) begin miss++; $display("FAIL first_req got %b@%h exp 1@0", ifureq_to_itcm, pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (ifureq_to_itcm !== 1'b1 || pc_from_ifu !== 32'h4) begin miss++; $display("FAIL second_req got %b@%h exp 1@4", ifureq_to_itcm, pc_from_ifu); end
        vecs++; if (inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL early_vld got %b exp 0", inst_valid_to_idu); end
        nxt(); @(negedge clk);
        vecs++; if (pc_from_ifu !== 32'h8) begin miss++; $display("FAIL third_req got %h exp 8", pc_from_ifu); end
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h0) begin miss++; $display("FAIL first_inst got %b@%h exp 1@0", inst_valid_to_idu, pc_to_idu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h4) begin miss++; $display("FAIL second_inst got %b@%h exp 1@4", inst_valid_to_idu, pc_to_idu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h8) begin miss++; $display("FAIL third_inst got %b@%h exp 1@8", inst_valid_to_idu, pc_to_idu); end
        nxt();
    endtask

    task automatic test_backpressure();
        idu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vecs++; if (ifureq_to_itcm !== 1'b0) begin miss++; $display("FAIL stall_req[%0d] got %b exp 0", i, ifureq_to_itcm); end
            vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'hC) begin miss++; $display("FAIL stall_head[%0d] got %b@%h exp 1@c", i, inst_valid_to_idu, pc_to_idu); end
            nxt();
        end
        idu_ready = 1'b1;
        @(negedge clk);
        vecs++; if (pc_to_idu !== 32'hC || ifureq_to_itcm !== 1'b1 || pc_from_ifu !== 32'h14) begin miss++; $display("FAIL drain0 got head %h req %b@%h exp c 1@14", pc_to_idu, ifureq_to_itcm, pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h10) begin miss++; $display("FAIL drain1 got %b@%h exp 1@10", inst_valid_to_idu, pc_to_idu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h14) begin miss++; $display("FAIL drain2 got %b@%h exp 1@14", inst_valid_to_idu, pc_to_idu); end
        nxt();
    endtask

    task automatic test_redirect();
        idu_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        vecs++; if (pc_from_ifu !== 32'h100 || ifureq_to_itcm !== 1'b1) begin miss++; $display("FAIL redir_req got %b@%h exp 1@100", ifureq_to_itcm, pc_from_ifu); end
        vecs++; if (inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL redir_vld got %b exp 0", inst_valid_to_idu); end
        nxt();
        redirect_valid = 1'b0; idu_ready = 1'b1;
        @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b0 || pc_from_ifu !== 32'h104) begin miss++; $display("FAIL redir_flush got vld %b pc %h exp 0 104", inst_valid_to_idu, pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h100 || inst_to_idu !== mk(32'h100)) begin miss++; $display("FAIL redir_first got %b@%h %h exp 1@100 %h", inst_valid_to_idu, pc_to_idu, inst_to_idu, mk(32'h100)); end
        nxt(); @(negedge clk);
        vecs++; if (pc_to_idu !== 32'h104) begin miss++; $display("FAIL redir_second got %h exp 104", pc_to_idu); end
        nxt();
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        vecs++; if (pc_from_ifu !== 32'hFFFF_FFF8) begin miss++; $display("FAIL wrap_redir got %h exp fffffff8", pc_from_ifu); end
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        vecs++; if (pc_from_ifu !== 32'hFFFF_FFFC || ifureq_to_itcm !== 1'b1) begin miss++; $display("FAIL wrap_top got %b@%h exp 1@fffffffc", ifureq_to_itcm, pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (pc_from_ifu !== 32'h0) begin miss++; $display("FAIL wrap_zero got %h exp 0", pc_from_ifu); end
        vecs++; if (pc_to_idu !== 32'hFFFF_FFF8) begin miss++; $display("FAIL wrap_head0 got %h exp fffffff8", pc_to_idu); end
        nxt(); @(negedge clk);
        vecs++; if (pc_to_idu !== 32'hFFFF_FFFC || pc_from_ifu !== 32'h4) begin miss++; $display("FAIL wrap_head1 got %h req %h exp fffffffc 4", pc_to_idu, pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h0) begin miss++; $display("FAIL wrap_head2 got %b@%h exp 1@0", inst_valid_to_idu, pc_to_idu); end
        nxt();
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
`ifdef IFU_MISALIGN_CHK_EN
        @(negedge clk);
        vecs++; if (ifureq_to_itcm !== 1'b0 || misalign_to_exu !== 1'b0) begin miss++; $display("FAIL mis_cycle got req %b mis %b exp 0/0", ifureq_to_itcm, misalign_to_exu); end
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        vecs++; if (misalign_to_exu !== 1'b1 || misalign_addr_to_exu !== 32'h102) begin miss++; $display("FAIL mis_pulse got %b@%h exp 1@102", misalign_to_exu, misalign_addr_to_exu); end
        vecs++; if (ifureq_to_itcm !== 1'b0 || inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL mis_err got req %b vld %b exp 0/0", ifureq_to_itcm, inst_valid_to_idu); end
        for (int i = 0; i < 2; i++) begin
            nxt(); @(negedge clk);
            vecs++; if (misalign_to_exu !== 1'b0 || ifureq_to_itcm !== 1'b0 || inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL mis_hold[%0d] got mis %b req %b vld %b exp 0/0/0", i, misalign_to_exu, ifureq_to_itcm, inst_valid_to_idu); end
        end
        nxt();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        vecs++; if (ifureq_to_itcm !== 1'b1 || pc_from_ifu !== 32'h200) begin miss++; $display("FAIL mis_exit got %b@%h exp 1@200", ifureq_to_itcm, pc_from_ifu); end
        nxt();
        redirect_valid = 1'b0;
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h200) begin miss++; $display("FAIL mis_resume got %b@%h exp 1@200", inst_valid_to_idu, pc_to_idu); end
        nxt();
`else
        @(negedge clk);
        vecs++; if (ifureq_to_itcm !== 1'b1 || pc_from_ifu !== 32'h100) begin miss++; $display("FAIL mis_mask got %b@%h exp 1@100", ifureq_to_itcm, pc_from_ifu); end
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        vecs++; if (misalign_to_exu !== 1'b0 || misalign_addr_to_exu !== 32'h0) begin miss++; $display("FAIL mis_tied got %b@%h exp 0@0", misalign_to_exu, misalign_addr_to_exu); end
        vecs++; if (pc_from_ifu !== 32'h104) begin miss++; $display("FAIL mis_next got %h exp 104", pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h100) begin miss++; $display("FAIL mis_fetch got %b@%h exp 1@100", inst_valid_to_idu, pc_to_idu); end
        nxt();
`endif
    endtask

    task automatic test_reset_mid();
        vecs++; if (inst_valid_to_idu !== 1'b1) begin miss++; $display("FAIL mid_pre got vld %b exp 1", inst_valid_to_idu); end
        rst_n = 1'b0;
        #1;
        vecs++; if (pc_from_ifu !== 32'h0 || ifureq_to_itcm !== 1'b0) begin miss++; $display("FAIL mid_rst_req got %b@%h exp 0@0", ifureq_to_itcm, pc_from_ifu); end
        vecs++; if (inst_valid_to_idu !== 1'b0 || inst_to_idu !== 32'h0 || pc_to_idu !== 32'h0) begin miss++; $display("FAIL mid_rst_idu got %b %h@%h exp 0 0@0", inst_valid_to_idu, inst_to_idu, pc_to_idu); end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vecs++; if (ifureq_to_itcm !== 1'b0 || inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL mid_idle got req %b vld %b exp 0/0", ifureq_to_itcm, inst_valid_to_idu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b0) begin miss++; $display("FAIL mid_stale got vld %b exp 0", inst_valid_to_idu); end
        vecs++; if (ifureq_to_itcm !== 1'b1 || pc_from_ifu !== 32'h0) begin miss++; $display("FAIL mid_restart got %b@%h exp 1@0", ifureq_to_itcm, pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b0 || pc_from_ifu !== 32'h4) begin miss++; $display("FAIL mid_second got vld %b pc %h exp 0 4", inst_valid_to_idu, pc_from_ifu); end
        nxt(); @(negedge clk);
        vecs++; if (inst_valid_to_idu !== 1'b1 || pc_to_idu !== 32'h0) begin miss++; $display("FAIL mid_first_inst got %b@%h exp 1@0", inst_valid_to_idu, pc_to_idu); end
        nxt();
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        idu_ready      = 1'b1;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter DW, default 32, instruction width.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc_from_ifu  output  AW  fetch address to ITCM.
REQ-007 SHALL have port ifureq_to_itcm  output  1  fetch request, one word per cycle high.
REQ-008 SHALL have port inst_to_ifu  input  DW  ITCM instruction data.
REQ-009 SHALL have port itcm_ready_to_ifu  input  1  ITCM response valid, exactly 1 cycle after request, no backpressure.
REQ-010 SHALL have port redirect_valid  input  1  branch/trap redirect strobe.
REQ-011 SHALL have port redirect_pc  input  AW  redirect target.
REQ-012 SHALL have port inst_valid_to_idu  output  1  instruction available to decode.
REQ-013 SHALL have port inst_to_idu  output  DW  instruction to decode.
REQ-014 SHALL have port pc_to_idu  output  AW  PC of inst_to_idu.
REQ-015 SHALL have port idu_ready  input  1  decode accepts head when high with inst_valid_to_idu.
REQ-016 SHALL have port misalign_to_exu  output  1  misaligned-redirect pulse.
REQ-017 SHALL have port misalign_addr_to_exu  output  AW  offending address.

Function
REQ-018 SHALL implement FSM IDLE, FETCH, ERR; reset enters IDLE; IDLE -> FETCH unconditionally after one cycle.
REQ-019 SHALL hold a 2-entry FIFO of {pc, inst}, an inflight flag, and fetch_pc.
REQ-020 SHALL drive pc_from_ifu = redirect_valid ? redirect_pc : fetch_pc, combinationally.
REQ-021 SHALL assert ifureq_to_itcm in FETCH when count + inflight - pop < 2, and in any state on an accepted redirect.
REQ-022 SHALL on issue set fetch_pc <= pc_from_ifu + 4, wrapping modulo 2^AW, and record the issued pc for the response.
REQ-023 SHALL push a response when itcm_ready_to_ifu is high, unless redirect_valid is high that cycle or state is ERR, which discards it.
REQ-024 SHALL never push into a full FIFO; the credit rule guarantees it and the bench asserts it.
REQ-025 SHALL drive inst_valid_to_idu = (count != 0) & !redirect_valid; head pops on inst_valid_to_idu & idu_ready.
REQ-026 SHALL support simultaneous push and pop in one cycle with count unchanged.
REQ-027 SHALL flush FIFO and inflight-tracking on redirect at the same edge; first redirected inst valid 2 cycles after the redirect cycle.
REQ-028 SHALL sustain 1 instruction/cycle when idu_ready is held high.

Reset
REQ-029 SHALL on rst_n low clear FSM to IDLE, FIFO count 0, inflight 0, fetch_pc = RESET_PC, all outputs 0 except pc_from_ifu = RESET_PC, asynchronously, including mid-transfer; a response arriving after reset release from a pre-reset request is discarded.

Configuration
REQ-030 SHALL compile misalignment checking only when IFU_MISALIGN_CHK_EN is defined.
REQ-031 SHALL, with IFU_MISALIGN_CHK_EN, on redirect with redirect_pc[1:0] != 0: issue no request, flush, pulse misalign_to_exu one cycle next edge with misalign_addr_to_exu = redirect_pc, enter ERR; ERR exits only on an aligned redirect, into FETCH.
REQ-032 SHALL, without IFU_MISALIGN_CHK_EN, use redirect_pc with bits [1:0] forced to 0, tie misalign outputs to 0, and never enter ERR.

Verification
REQ-033 Reset release, idu_ready=1, ITCM models 1-cycle latency -> requests at 0x0,0x4,0x8 on consecutive cycles; inst_valid_to_idu continuous from the 3rd cycle after IDLE, pc_to_idu 0x0,0x4,0x8.
REQ-034 idu_ready=0 for 5 cycles -> at most 2 buffered, ifureq_to_itcm low once count+inflight=2, no response lost; idu_ready=1 -> in-order drain.
REQ-035 redirect_valid with redirect_pc=0x100 while FIFO full and response in flight -> in-flight response dropped, pc_from_ifu=0x100 same cycle, pc_to_idu=0x100 two cycles later.
REQ-036 fetch_pc=0xFFFF_FFFC issued -> next request pc 0x0000_0000.
REQ-037 With IFU_MISALIGN_CHK_EN, redirect_pc=0x102 -> misalign_to_exu pulses once with addr 0x102, no requests until redirect 0x200; without the macro, fetch at 0x100.
REQ-038 rst_n asserted mid-stream with FIFO holding 1 entry -> all outputs 0 immediately; restart from RESET_PC.
